// File: rtl/sub_bytes_pipe.sv
// Pipelined multi-lane AES S-box / inverse S-box with valid/ready flow control and flush.
// Substitution uses GF(2^8) inversion plus the (inverse) affine map; later stages are pure delay.
module sub_bytes_pipe #(
  parameter int NUM_BYTES   = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   inMode,
  input  logic [8*NUM_BYTES-1:0] inData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   outMode,
  output logic [8*NUM_BYTES-1:0] outData,
  output logic [2:0]             inFlight
);

  localparam int W = 8 * NUM_BYTES;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    x252 = gfMul(x240, x12);
    return gfMul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] fwdSbox(input logic [7:0] x);
    logic [7:0] b;
    b = gfInv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return gfInv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  logic [W-1:0]           subData;
  logic [PIPE_STAGES-1:0] validReg;
  logic [PIPE_STAGES-1:0] modeReg;
  logic [W-1:0]           dataReg [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] adv;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : gLane
      assign subData[8*gi +: 8] = inMode ? invSbox(inData[8*gi +: 8])
                                         : fwdSbox(inData[8*gi +: 8]);
    end
  endgenerate

  // A stage may load when it is empty or when the stage after it is moving.
  always_comb begin
    adv = '0;
    adv[PIPE_STAGES-1] = !validReg[PIPE_STAGES-1] | outReady;
    for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
      adv[k] = !validReg[k] | adv[k+1];
    end
  end

  assign inReady = adv[0] & !flush;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      validReg <= '0;
      modeReg  <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) dataReg[k] <= '0;
    end else begin
      if (adv[0]) begin
        validReg[0] <= inValid;
        modeReg[0]  <= inMode;
        dataReg[0]  <= subData;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (adv[k]) begin
          validReg[k] <= validReg[k-1];
          modeReg[k]  <= modeReg[k-1];
          dataReg[k]  <= dataReg[k-1];
        end
      end
      // Flush overrides every load above, including the one from the input.
      if (flush) validReg <= '0;
    end
  end

  always_comb begin
    inFlight = '0;
    for (int k = 0; k < PIPE_STAGES; k++) inFlight = inFlight + 3'(validReg[k]);
  end

  assign outValid = validReg[PIPE_STAGES-1];
  assign outMode  = modeReg[PIPE_STAGES-1];
  assign outData  = dataReg[PIPE_STAGES-1];

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Self-checking bench for sub_bytes_pipe: reference S-boxes are built from log/antilog
// tables and the bitwise affine formula, and streams are checked against a queue model.
module tb_sub_bytes_pipe;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         flush = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic         inMode = 1'b0;
  logic [127:0] inData = '0;
  logic         outValid;
  logic         outReady = 1'b1;
  logic         outMode;
  logic [127:0] outData;
  logic [2:0]   inFlight;

  logic        sInValid = 1'b0;
  logic        sMode = 1'b0;
  logic [31:0] sData = '0;
  logic        aInReady, aOutValid, aOutMode, bInReady, bOutValid, bOutMode;
  logic [31:0] aOutData, bOutData;
  logic [2:0]  aInFlight, bInFlight;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]   fwdTab [256];
  logic [7:0]   invTab [256];
  logic [128:0] expQ [$];

  always #5 clk = ~clk;

  sub_bytes_pipe #(.NUM_BYTES(16), .PIPE_STAGES(S)) dut (
    .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(inReady),
    .inMode(inMode), .inData(inData), .outValid(outValid), .outReady(outReady),
    .outMode(outMode), .outData(outData), .inFlight(inFlight));

  sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(1)) dutA (
    .clk(clk), .rstN(rstN), .flush(1'b0), .inValid(sInValid), .inReady(aInReady),
    .inMode(sMode), .inData(sData), .outValid(aOutValid), .outReady(1'b1),
    .outMode(aOutMode), .outData(aOutData), .inFlight(aInFlight));

  sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(4)) dutB (
    .clk(clk), .rstN(rstN), .flush(1'b0), .inValid(sInValid), .inReady(bInReady),
    .inMode(sMode), .inData(sData), .outValid(bOutValid), .outReady(1'b1),
    .outMode(bOutMode), .outData(bOutData), .inFlight(bInFlight));

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic buildTables();
    int         logT [256];
    logic [7:0] expT [255];
    logic [7:0] p, b, s, c;
    c = 8'h63;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      expT[i] = p;
      logT[p] = i;
      p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : expT[(255 - logT[x]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      fwdTab[x] = s;
      invTab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] refSub(input logic [127:0] d, input logic m, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[8*i +: 8] = m ? invTab[d[8*i +: 8]] : fwdTab[d[8*i +: 8]];
    return r;
  endfunction

  // Drives one cycle of inputs, samples handshake/outputs just after, and returns at the next negedge.
  task automatic drive(input logic v, input logic m, input logic [127:0] d, input logic r,
                       input logic fl, output logic acc, output logic emt,
                       output logic [127:0] oD, output logic oM);
    inValid = v; inMode = m; inData = d; outReady = r; flush = fl;
    #1;
    acc = v & inReady;
    emt = outValid & r;
    oD = outData;
    oM = outMode;
    @(negedge clk);
  endtask

  task automatic sendOne(input logic [127:0] d, input logic m, output logic acc,
                         output logic early, output logic got,
                         output logic [127:0] oD, output logic oM);
    logic a, e, om;
    logic [127:0] od;
    drive(1'b1, m, d, 1'b1, 1'b0, acc, e, od, om);
    early = e; got = 1'b0; oD = '0; oM = 1'b0;
    for (int k = 1; k <= S; k++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, a, e, od, om);
      if (k < S) early = early | e;
      else begin got = e; oD = od; oM = om; end
    end
  endtask

  task automatic test_reset();
    #3;
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL reset_outValid: got %b want 0", outValid); end
    compared++; if (outData !== '0) begin mismatched++; $display("FAIL reset_outData: got %h want 0", outData); end
    compared++; if (outMode !== 1'b0) begin mismatched++; $display("FAIL reset_outMode: got %b want 0", outMode); end
    compared++; if (inFlight !== 3'd0) begin mismatched++; $display("FAIL reset_inFlight: got %0d want 0", inFlight); end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL reset_inReady: got %b want 1", inReady); end
  endtask

  task automatic test_forward();
    logic acc, early, got, om;
    logic [127:0] od;
    sendOne(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, acc, early, got, od, om);
    $display("t1 fwd: out=%h mode=%b", od, om);
    compared++; if (acc !== 1'b1) begin mismatched++; $display("FAIL t1_accept: got %b want 1", acc); end
    compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL t1_early: got %b want 0", early); end
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL t1_latency: got %b want 1", got); end
    compared++; if (od !== 128'hd42711aee0bf98f1b8b45de51e415230) begin mismatched++; $display("FAIL t1_data: got %h want d42711aee0bf98f1b8b45de51e415230", od); end
    compared++; if (om !== 1'b0) begin mismatched++; $display("FAIL t1_mode: got %b want 0", om); end
  endtask

  task automatic test_inverse();
    logic acc, early, got, om;
    logic [127:0] od;
    sendOne(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, acc, early, got, od, om);
    $display("t2 inv: out=%h mode=%b", od, om);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL t2_valid: got %b want 1", got); end
    compared++; if (od !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin mismatched++; $display("FAIL t2_data: got %h want 193de3bea0f4e22b9ac68d2ae9f84808", od); end
    compared++; if (om !== 1'b1) begin mismatched++; $display("FAIL t2_mode: got %b want 1", om); end
    sendOne({112'h0, 8'h53, 8'h00}, 1'b0, acc, early, got, od, om);
    $display("t2 spot fwd: lanes1..0=%h", od[15:0]);
    compared++; if (od[15:0] !== 16'hed63) begin mismatched++; $display("FAIL t2_spot_fwd: got %h want ed63", od[15:0]); end
    sendOne({104'h0, 8'hff, 8'h00, 8'h63}, 1'b1, acc, early, got, od, om);
    $display("t2 spot inv: lanes2..0=%h", od[23:0]);
    compared++; if (od[23:0] !== 24'h7d5200) begin mismatched++; $display("FAIL t2_spot_inv: got %h want 7d5200", od[23:0]); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] txD [8];
    logic         txM [8];
    logic acc, emt, om, v, m;
    logic [127:0] od, d, want;
    int idx;
    for (int i = 0; i < 8; i++) begin
      txD[i] = {$urandom, $urandom, $urandom, $urandom};
      txM[i] = (i % 2) == 1;
    end
    for (int t = 0; t < 8 + S + 2; t++) begin
      v = t < 8;
      m = v ? txM[t] : 1'b0;
      d = v ? txD[t] : '0;
      drive(v, m, d, 1'b1, 1'b0, acc, emt, od, om);
      idx = t - S;
      $display("t3 cycle %0d: acc=%b outValid=%b mode=%b data=%h", t, acc, emt, om, od);
      if (v) begin
        compared++; if (acc !== 1'b1) begin mismatched++; $display("FAIL t3_accept[%0d]: got %b want 1", t, acc); end
      end
      compared++;
      if (emt !== (idx >= 0 && idx < 8)) begin mismatched++; $display("FAIL t3_valid[%0d]: got %b want %b", t, emt, idx >= 0 && idx < 8); end
      if (idx >= 0 && idx < 8) begin
        want = refSub(txD[idx], txM[idx], 16);
        compared++;
        if ({om, od} !== {txM[idx], want}) begin mismatched++; $display("FAIL t3_data[%0d]: got %b/%h want %b/%h", idx, om, od, txM[idx], want); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, emt, om, m;
    logic [127:0] od, d;
    logic [128:0] e;
    int accepted = 0;
    int delivered = 0;
    expQ.delete();
    for (int c = 0; c < 5; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      drive(1'b1, m, d, 1'b0, 1'b0, acc, emt, od, om);
      if (acc) begin accepted++; expQ.push_back({m, refSub(d, m, 16)}); end
      if (c >= 2) begin
        e = expQ[0];
        compared++;
        if ({om, od} !== e) begin mismatched++; $display("FAIL t4_stall_hold[%0d]: got %b/%h want %b/%h", c, om, od, e[128], e[127:0]); end
      end
    end
    #1;
    $display("t4 stalled: inFlight=%0d inReady=%b accepted=%0d", inFlight, inReady, accepted);
    compared++; if (inFlight !== 3'(S)) begin mismatched++; $display("FAIL t4_inFlight: got %0d want %0d", inFlight, S); end
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL t4_inReady: got %b want 0", inReady); end
    compared++; if (accepted !== S) begin mismatched++; $display("FAIL t4_accepted: got %0d want %0d", accepted, S); end
    for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, acc, emt, od, om);
      if (emt) begin
        e = expQ.pop_front();
        delivered++;
        $display("t4 drain: mode=%b data=%h", om, od);
        compared++;
        if ({om, od} !== e) begin mismatched++; $display("FAIL t4_order: got %b/%h want %b/%h", om, od, e[128], e[127:0]); end
      end
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, acc, emt, od, om);
    compared++; if (delivered + (emt ? 1 : 0) !== accepted) begin mismatched++; $display("FAIL t4_count: got %0d want %0d", delivered + (emt ? 1 : 0), accepted); end
  endtask

  task automatic test_flush();
    logic acc, emt, om;
    logic [127:0] od;
    int emits = 0;
    drive(1'b1, 1'b0, 128'h1111, 1'b0, 1'b0, acc, emt, od, om);
    drive(1'b1, 1'b1, 128'h2222, 1'b0, 1'b0, acc, emt, od, om);
    drive(1'b1, 1'b0, 128'h3333, 1'b0, 1'b1, acc, emt, od, om);
    compared++; if (acc !== 1'b0) begin mismatched++; $display("FAIL t5_flush_accept: got %b want 0", acc); end
    #1;
    $display("t5 after flush: inFlight=%0d outValid=%b", inFlight, outValid);
    compared++; if (inFlight !== 3'd0) begin mismatched++; $display("FAIL t5_inFlight: got %0d want 0", inFlight); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL t5_outValid: got %b want 0", outValid); end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, acc, emt, od, om);
      if (emt) emits++;
    end
    compared++; if (emits !== 0) begin mismatched++; $display("FAIL t5_ghost: got %0d emits want 0", emits); end
  endtask

  task automatic test_async_reset();
    logic acc, early, got, om, emt;
    logic [127:0] od;
    drive(1'b1, 1'b0, 128'hdead, 1'b0, 1'b0, acc, emt, od, om);
    drive(1'b1, 1'b1, 128'hbeef, 1'b0, 1'b0, acc, emt, od, om);
    #2;
    inValid = 1'b0; outReady = 1'b1;
    rstN = 1'b0;
    #1;
    $display("t6 in reset: outValid=%b outData=%h inFlight=%0d", outValid, outData, inFlight);
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL t6_outValid: got %b want 0", outValid); end
    compared++; if (outData !== '0) begin mismatched++; $display("FAIL t6_outData: got %h want 0", outData); end
    compared++; if (inFlight !== 3'd0) begin mismatched++; $display("FAIL t6_inFlight: got %0d want 0", inFlight); end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL t6_inReady: got %b want 1", inReady); end
    sendOne(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, acc, early, got, od, om);
    $display("t6 t1 again: valid=%b out=%h", got, od);
    compared++; if ({early, got, od} !== {1'b0, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230}) begin mismatched++; $display("FAIL t6_t1: got %b%b/%h want 01/d42711aee0bf98f1b8b45de51e415230", early, got, od); end
  endtask

  task automatic test_random();
    logic acc, emt, om, v, r, m, expReady;
    logic [127:0] od, d;
    logic [128:0] e;
    expQ.delete();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      m = 1'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      expReady = !(expQ.size() == S && !r);
      drive(v, m, d, r, 1'b0, acc, emt, od, om);
      $display("rand %0d: in v=%b r=%b acc=%b emit=%b mode=%b data=%h", c, v, r, acc, emt, om, od);
      compared++;
      if (acc !== (v & expReady)) begin mismatched++; $display("FAIL rand_accept[%0d]: got %b want %b", c, acc, v & expReady); end
      if (emt) begin
        compared++;
        if (expQ.size() == 0) begin mismatched++; $display("FAIL rand_spurious[%0d]: got emit want none", c); end
        else begin
          e = expQ.pop_front();
          if ({om, od} !== e) begin mismatched++; $display("FAIL rand_data[%0d]: got %b/%h want %b/%h", c, om, od, e[128], e[127:0]); end
        end
      end
      if (acc) expQ.push_back({m, refSub(d, m, 16)});
      #1;
      compared++;
      if (inFlight !== 3'(expQ.size())) begin mismatched++; $display("FAIL rand_inFlight[%0d]: got %0d want %0d", c, inFlight, expQ.size()); end
    end
    for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, acc, emt, od, om);
      if (emt) begin
        e = expQ.pop_front();
        compared++;
        if ({om, od} !== e) begin mismatched++; $display("FAIL rand_drain: got %b/%h want %b/%h", om, od, e[128], e[127:0]); end
      end
    end
    compared++; if (expQ.size() != 0) begin mismatched++; $display("FAIL rand_leftover: got %0d want 0", expQ.size()); end
  endtask

  task automatic test_small_configs();
    logic [31:0]  txD [9];
    logic         txM [9];
    logic [127:0] r;
    logic [31:0]  want;
    int ia, ib;
    txD[0] = 32'he9f84808; txM[0] = 1'b0;
    for (int i = 1; i < 9; i++) begin txD[i] = $urandom; txM[i] = (i % 2) == 1; end
    for (int t = 0; t < 9 + 4 + 2; t++) begin
      sInValid = t < 9;
      sMode = (t < 9) ? txM[t] : 1'b0;
      sData = (t < 9) ? txD[t] : '0;
      #1;
      ia = t - 1;
      ib = t - 4;
      $display("small cycle %0d: S1 v=%b %b/%h  S4 v=%b %b/%h", t, aOutValid, aOutMode, aOutData, bOutValid, bOutMode, bOutData);
      compared++; if (aOutValid !== (ia >= 0 && ia < 9)) begin mismatched++; $display("FAIL s1_valid[%0d]: got %b want %b", t, aOutValid, ia >= 0 && ia < 9); end
      if (ia >= 0 && ia < 9) begin
        r = refSub({96'h0, txD[ia]}, txM[ia], 4);
        want = (ia == 0) ? 32'h1e415230 : r[31:0];
        compared++;
        if ({aOutMode, aOutData} !== {txM[ia], want}) begin mismatched++; $display("FAIL s1_data[%0d]: got %b/%h want %b/%h", ia, aOutMode, aOutData, txM[ia], want); end
      end
      compared++; if (bOutValid !== (ib >= 0 && ib < 9)) begin mismatched++; $display("FAIL s4_valid[%0d]: got %b want %b", t, bOutValid, ib >= 0 && ib < 9); end
      if (ib >= 0 && ib < 9) begin
        r = refSub({96'h0, txD[ib]}, txM[ib], 4);
        want = (ib == 0) ? 32'h1e415230 : r[31:0];
        compared++;
        if ({bOutMode, bOutData} !== {txM[ib], want}) begin mismatched++; $display("FAIL s4_data[%0d]: got %b/%h want %b/%h", ib, bOutMode, bOutData, txM[ib], want); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    buildTables();
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_small_configs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
